// File: rtl/rv_mc_sequencer_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the
// instruction/data memories. The sequencer is the master (raises requests),
// the memories are the slave (return acks and the fetched word).
interface rv_mc_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic            imem_ack;
    logic [XLEN-1:0] instruction;
    logic            dmem_req;
    logic            dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  instruction,
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output instruction,
        input  dmem_req,
        output dmem_ack
    );
endinterface

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle control sequencer for the RV32 core. Steps each instruction
// through FETCH, DECODE, EXECUTE, (MEM), WB over a req/ack memory handshake,
// holds the current instruction and observation output, and keeps saturating
// retired-instruction and busy-cycle counters. Every output is either a
// register or a decode of the registered state, so no input reaches an
// output combinationally.
module rv_mc_sequencer #(
    parameter int              XLEN      = 32,
    parameter int              CNT_W     = 32,
    parameter logic [XLEN-1:0] HALT_INSN = {XLEN{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    rv_mc_sequencer_if.master mem_bus,
    input  logic             start_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic             reg_write_i,
    input  logic             out_type_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic [XLEN-1:0]  ir_o,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic [XLEN-1:0]  out_o,
    output logic             out_valid_o,
    output logic             exit_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] cycles_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic [2:0]       state_q,   state_d;
    logic [XLEN-1:0]  ir_q,      ir_d;
    logic [XLEN-1:0]  out_q,     out_d;
    logic             exit_q,    exit_d;
    logic             rf_we_q,   rf_we_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] cycles_q,  cycles_d;

    logic fetch_done_s;
    logic is_halt_s;
    logic busy_s;
    logic in_wb_s;

    assign fetch_done_s = (state_q == S_FETCH) && mem_bus.imem_ack;
    assign is_halt_s    = (mem_bus.instruction == HALT_INSN);
    assign busy_s       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign in_wb_s      = (state_q == S_WB);

    // Next-state selection for the instruction sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_bus.imem_ack) begin
                    if (is_halt_s) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_DECODE;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (mem_read_i || mem_write_i) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_bus.dmem_ack) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:      state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values for the instruction, output, exit, enable and counter registers.
    always_comb begin
        ir_d      = ir_q;
        out_d     = out_q;
        exit_d    = exit_q;
        retired_d = retired_q;
        cycles_d  = cycles_q;
        if (fetch_done_s) begin
            ir_d   = mem_bus.instruction;
            exit_d = exit_q | is_halt_s;
        end else begin
            ir_d   = ir_q;
            exit_d = exit_q;
        end
        if (in_wb_s) begin
            out_d     = out_type_i ? pc_i : wb_data_i;
            retired_d = sat_inc(retired_q);
        end else begin
            out_d     = out_q;
            retired_d = retired_q;
        end
        if (busy_s) begin
            cycles_d = sat_inc(cycles_q);
        end else begin
            cycles_d = cycles_q;
        end
        // reg_write is held by the control unit for the whole instruction, so
        // sampling it on the edge into WB gives a registered rf_we for WB.
        rf_we_d = (state_d == S_WB) && reg_write_i;
    end

    // State and datapath-control registers; rst clears everything at once,
    // which also drops any outstanding memory request asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= {XLEN{1'b0}};
            out_q     <= {XLEN{1'b0}};
            exit_q    <= 1'b0;
            rf_we_q   <= 1'b0;
            retired_q <= {CNT_W{1'b0}};
            cycles_q  <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            out_q     <= out_d;
            exit_q    <= exit_d;
            rf_we_q   <= rf_we_d;
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    assign mem_bus.imem_req = (state_q == S_FETCH);
    assign mem_bus.dmem_req = (state_q == S_MEM);
    assign ir_o             = ir_q;
    assign rf_we_o          = rf_we_q;
    assign pc_we_o          = in_wb_s;
    assign out_o            = out_q;
    assign out_valid_o      = in_wb_s;
    assign exit_o           = exit_q;
    assign busy_o           = busy_s;
    assign retired_o        = retired_q;
    assign cycles_o         = cycles_q;

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Self-checking bench for rv_mc_sequencer. A behavioural model expands each
// instruction into its expected per-cycle phase sequence (fetch cycles,
// decode, execute, optional memory cycles, write-back) and tracks counters
// and the output register; a second instance with 3-bit counters exercises
// saturation.
module tb_rv_mc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mem_read, mem_write, reg_write, out_type;
    logic [31:0] wb_data, pc_v;

    logic [31:0] ir, out;
    logic        rf_we, pc_we, out_valid, exit_f, busy;
    logic [31:0] retired, cycles;

    logic [31:0] ir_s, out_s;
    logic        rf_we_s, pc_we_s, out_valid_s, exit_s, busy_s;
    logic [2:0]  retired_s, cycles_s;

    rv_mc_sequencer_if #(.XLEN(32)) bus ();
    rv_mc_sequencer_if #(.XLEN(32)) bus_s ();
    assign bus_s.imem_ack    = bus.imem_ack;
    assign bus_s.instruction = bus.instruction;
    assign bus_s.dmem_ack    = bus.dmem_ack;

    rv_mc_sequencer #(.XLEN(32), .CNT_W(32), .HALT_INSN(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .mem_bus(bus), .start_i(start),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .reg_write_i(reg_write),
        .out_type_i(out_type), .wb_data_i(wb_data), .pc_i(pc_v),
        .ir_o(ir), .rf_we_o(rf_we), .pc_we_o(pc_we), .out_o(out),
        .out_valid_o(out_valid), .exit_o(exit_f), .busy_o(busy),
        .retired_o(retired), .cycles_o(cycles)
    );

    rv_mc_sequencer #(.XLEN(32), .CNT_W(3), .HALT_INSN(32'h0000_0000)) dut_s (
        .clk(clk), .rst(rst), .mem_bus(bus_s), .start_i(start),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .reg_write_i(reg_write),
        .out_type_i(out_type), .wb_data_i(wb_data), .pc_i(pc_v),
        .ir_o(ir_s), .rf_we_o(rf_we_s), .pc_we_o(pc_we_s), .out_o(out_s),
        .out_valid_o(out_valid_s), .exit_o(exit_s), .busy_o(busy_s),
        .retired_o(retired_s), .cycles_o(cycles_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          cycles_m  = 0;
    int          retired_m = 0;
    logic [31:0] out_m     = 32'h0;

    typedef struct packed {
        logic ireq, dreq, rfwe, pcwe, ov;
        logic in_fetch, last_fetch, in_mem, last_mem;
    } cyc_t;
    cyc_t trace_q[$];

    typedef struct {
        int          wi;
        bit          rd, wr;
        int          wd;
        bit          rw, ot;
        logic [31:0] wbd, pcv, insn, exp_out;
        int          exp_off, exp_ireq, exp_dreq;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] sat3(input int v);
        return (v > 7) ? 64'd7 : 64'(v);
    endfunction

    function automatic logic noise();
        return $urandom_range(0, 1) != 0;
    endfunction

    // Expected phase sequence of one instruction: wi+1 fetch cycles, decode,
    // execute, wd+1 memory cycles when it accesses memory, then write-back.
    task automatic build_trace(input int wi, input bit mem, input int wd, input bit rw);
        cyc_t c;
        trace_q.delete();
        for (int i = 0; i <= wi; i++) begin
            c = '0; c.ireq = 1'b1; c.in_fetch = 1'b1; c.last_fetch = (i == wi);
            trace_q.push_back(c);
        end
        c = '0;
        trace_q.push_back(c);
        trace_q.push_back(c);
        if (mem) begin
            for (int i = 0; i <= wd; i++) begin
                c = '0; c.dreq = 1'b1; c.in_mem = 1'b1; c.last_mem = (i == wd);
                trace_q.push_back(c);
            end
        end
        c = '0; c.rfwe = rw; c.pcwe = 1'b1; c.ov = 1'b1;
        trace_q.push_back(c);
    endtask

    // Drive one instruction starting in FETCH (called #1 after a rising edge).
    task automatic run_insn(input int wi, input bit rd, input bit wr, input int wd,
                            input bit rw, input bit ot, input logic [31:0] wbd,
                            input logic [31:0] pcv, input logic [31:0] insn,
                            output int wb_off, output int ireq_n, output int dreq_n);
        cyc_t       c;
        logic [5:0] ev;
        mem_read = rd; mem_write = wr; reg_write = rw; out_type = ot;
        wb_data = wbd; pc_v = pcv;
        build_trace(wi, rd | wr, wd, rw);
        wb_off = -1; ireq_n = 0; dreq_n = 0;
        for (int k = 0; k < trace_q.size(); k++) begin
            c = trace_q[k];
            bus.imem_ack    = c.in_fetch ? c.last_fetch : noise();
            bus.instruction = c.last_fetch ? insn : ($urandom() | 32'h1);
            bus.dmem_ack    = c.in_mem ? c.last_mem : noise();
            start           = noise();
            @(negedge clk);
            ev = {c.ireq, c.dreq, c.rfwe, c.pcwe, c.ov, 1'b1};
            chk($sformatf("ctl[%0d]", k),
                {52'd0, bus.imem_req, bus.dmem_req, rf_we, pc_we, out_valid, busy,
                 bus_s.imem_req, bus_s.dmem_req, rf_we_s, pc_we_s, out_valid_s, busy_s},
                {52'd0, ev, ev});
            if (bus.imem_req) ireq_n++;
            if (bus.dmem_req) dreq_n++;
            if (out_valid && wb_off < 0) wb_off = k;
            @(posedge clk); #1;
        end
        cycles_m  += trace_q.size();
        retired_m += 1;
        out_m      = ot ? pcv : wbd;
        chk("out", {32'd0, out}, {32'd0, out_m});
        chk("out_s", {32'd0, out_s}, {32'd0, out_m});
        chk("ir", {ir, ir_s}, {insn, insn});
        chk("retired", {32'd0, retired}, 64'(retired_m));
        chk("cycles", {32'd0, cycles}, 64'(cycles_m));
        chk("retired_sat", {61'd0, retired_s}, sat3(retired_m));
        chk("cycles_sat", {61'd0, cycles_s}, sat3(cycles_m));
        chk("exit_low", {62'd0, exit_f, exit_s}, 64'd0);
    endtask

    initial begin
        int off, ni, nd, wi, wd;
        bit rd, wr, rw, ot;
        logic [31:0] wbd, pcv, insn;

        vecs[0] = '{0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'd5, 32'h0, 32'h00500093, 32'd5, 3, 1, 0};
        vecs[1] = '{2, 1'b1, 1'b0, 3, 1'b1, 1'b0, 32'hDEADBEEF, 32'h4, 32'h00002103, 32'hDEADBEEF, 9, 3, 4};
        vecs[2] = '{0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h1234, 32'h10, 32'h00000013, 32'h10, 3, 1, 0};
        vecs[3] = '{1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'hA5A50000, 32'h20, 32'h00112023, 32'hA5A50000, 5, 2, 1};
        vecs[4] = '{0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFC, 3, 1, 0};

        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; out_type = 1'b0; wb_data = 32'h0; pc_v = 32'h0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.instruction = 32'h0;

        // Reset held for 3 cycles, then idle with start low.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_ctl", {57'd0, bus.imem_req, bus.dmem_req, rf_we, pc_we, out_valid, busy, exit_f}, 64'd0);
            chk("reset_regs", {ir, out}, 64'd0);
            chk("reset_cnt", {retired, cycles}, 64'd0);
            @(posedge clk); #1;
        end

        // Start pulse moves the block into FETCH.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_insn(vecs[v].wi, vecs[v].rd, vecs[v].wr, vecs[v].wd, vecs[v].rw, vecs[v].ot,
                     vecs[v].wbd, vecs[v].pcv, vecs[v].insn, off, ni, nd);
            chk($sformatf("tbl%0d_out", v), {32'd0, out}, {32'd0, vecs[v].exp_out});
            chk($sformatf("tbl%0d_wb_offset", v), 64'(off), 64'(vecs[v].exp_off));
            chk($sformatf("tbl%0d_imem_req_cycles", v), 64'(ni), 64'(vecs[v].exp_ireq));
            chk($sformatf("tbl%0d_dmem_req_cycles", v), 64'(nd), 64'(vecs[v].exp_dreq));
        end

        // Randomized instruction stream.
        for (int r = 0; r < 40; r++) begin
            wi = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            rd = 1'b0; wr = 1'b0;
            case ($urandom_range(0, 2))
                0:       rd = 1'b1;
                1:       wr = 1'b1;
                default: ;
            endcase
            rw = noise(); ot = noise();
            wbd = $urandom(); pcv = $urandom() & 32'hFFFFFFFC; insn = $urandom() | 32'h1;
            run_insn(wi, rd, wr, wd, rw, ot, wbd, pcv, insn, off, ni, nd);
            chk("rnd_wb_offset", 64'(off), 64'(wi + 3 + ((rd | wr) ? wd + 1 : 0)));
            chk("rnd_imem_req_cycles", 64'(ni), 64'(wi + 1));
            chk("rnd_dmem_req_cycles", 64'(nd), 64'((rd | wr) ? wd + 1 : 0));
        end

        // Halt: one wait cycle (word is already HALT but not acked), then ack.
        bus.imem_ack = 1'b0; bus.instruction = 32'h0; bus.dmem_ack = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("halt_wait", {58'd0, bus.imem_req, bus.dmem_req, rf_we, pc_we, out_valid, busy}, 64'b100001);
        @(posedge clk); #1;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        chk("halt_ack", {58'd0, bus.imem_req, bus.dmem_req, rf_we, pc_we, out_valid, busy}, 64'b100001);
        @(posedge clk); #1;
        cycles_m += 2;
        chk("halt_exit_busy", {60'd0, exit_f, busy, exit_s, busy_s}, 64'b1010);
        chk("halt_retired", {32'd0, retired}, 64'(retired_m));
        chk("halt_cycles", {32'd0, cycles}, 64'(cycles_m));
        chk("halt_ir", {32'd0, ir}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1; bus.instruction = $urandom();
            @(negedge clk);
            chk("halt_stuck", {57'd0, bus.imem_req, bus.dmem_req, rf_we, pc_we, out_valid, busy, exit_f}, 64'b0000001);
            chk("halt_counters", {retired, cycles}, {32'(retired_m), 32'(cycles_m)});
            @(posedge clk); #1;
        end

        // Reset clears exit; then drive a load into MEM and reset mid-access.
        start = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_clears_exit", {62'd0, exit_f, exit_s}, 64'd0);
        chk("rst_clears_cnt", {retired, cycles}, 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        bus.imem_ack = 1'b1; bus.instruction = 32'h00002003;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mem_req_before_rst", {63'd0, bus.dmem_req}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mem_req_async_drop", {62'd0, bus.dmem_req, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ack_idle", {57'd0, bus.imem_req, bus.dmem_req, rf_we, pc_we, out_valid, busy, exit_f}, 64'd0);
            chk("stray_ack_cnt", {retired, cycles}, 64'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
